data_memory_loader: RTL

Boot-time loader that sits directly upstream of the BIP2 data memory and fills it from an 8-bit byte stream (UART receiver or test harness) before the processor is released. It parses a 16-bit word-count header, assembles little-endian bytes into DATA_WIDTH words and drives the memory write port at consecutive addresses from 0. `busy_out` holds the core off; the address/data/write outputs are muxed onto the data memory port while busy.

---
 rtl/data_memory_loader_pkg.sv | 22 ++
 rtl/data_memory_loader_word_assembler.sv | 47 ++++
 rtl/data_memory_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/data_memory_loader_pkg.sv
// Shared types and constants for the BIP2 boot-time data memory loader.
package bip2_loader_pkg;

  localparam int HEADER_BYTES = 2;
  localparam int COUNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  // A header asking for more words than the memory holds is rejected up front.
  function automatic logic count_exceeds_depth(input logic [COUNT_WIDTH-1:0] count,
                                               input int address_width);
    return 32'(count) > (32'd1 << address_width);
  endfunction

endpackage

// File: rtl/data_memory_loader_word_assembler.sv
// Little-endian byte-to-word assembler: the first byte shifted in lands in bits [7:0].
module word_assembler #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_complete
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0]      index;
  logic [DATA_WIDTH-1:0] next_word;

  assign word_complete = shift && (index == LAST_IDX);

  // Bytes enter at the top and drift down, so after BYTES shifts byte 0 sits at [7:0].
  generate
    if (BYTES > 1) begin : g_multi
      assign next_word = {byte_data, word[DATA_WIDTH-1:8]};
    end else begin : g_single
      assign next_word = byte_data;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index <= '0;
      word  <= '0;
    end else if (clear) begin
      index <= '0;
      word  <= '0;
    end else if (shift) begin
      index <= word_complete ? '0 : index + 1'b1;
      word  <= next_word;
    end
  end

endmodule

// File: rtl/data_memory_loader.sv
// Boot loader: parses a word-count header, then streams little-endian words
// into the data memory at consecutive addresses from 0 while holding the core off.
module data_memory_loader
  import bip2_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     start_in,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid_in,
  output logic                     byte_ready_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [ADDRESS_WIDTH-1:0] address_out,
  output logic                     data_memory_wr_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     error_out,
  output logic [ADDRESS_WIDTH:0]   words_loaded_out
);

  localparam int HDR_IDX_W = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
  localparam logic [HDR_IDX_W-1:0] HDR_LAST = HDR_IDX_W'(HEADER_BYTES - 1);

  loader_state_t            state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic [COUNT_WIDTH-1:0]   header_value;
  logic [HDR_IDX_W-1:0]     hdr_idx_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [ADDRESS_WIDTH:0]   words_q;
  logic [ADDRESS_WIDTH:0]   words_next;
  logic                     accept;
  logic                     start_ok;
  logic                     header_last;
  logic                     last_word;
  logic                     data_shift;
  logic                     word_complete;
  logic [DATA_WIDTH-1:0]    word;

  assign accept       = byte_valid_in && byte_ready_out;
  assign start_ok     = start_in && (state_q inside {IDLE, DONE, ERROR});
  assign header_last  = (state_q == HEADER) && accept && (hdr_idx_q == HDR_LAST);
  assign header_value = {byte_in, count_q[COUNT_WIDTH-1:8]};
  assign words_next   = words_q + 1'b1;
  assign last_word    = (32'(words_next) == 32'(count_q));
  assign data_shift   = accept && (state_q == DATA);

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_assembler (
    .clk          (clock_in),
    .rst          (reset_in),
    .clear        (start_ok),
    .shift        (data_shift),
    .byte_data    (byte_in),
    .word         (word),
    .word_complete(word_complete)
  );

  // The assembler holds its word through WRITE because no byte is accepted then.
  assign data_out         = word;
  assign address_out      = address_q;
  assign words_loaded_out = words_q;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d            = state_q;
    byte_ready_out     = 1'b0;
    busy_out           = 1'b0;
    data_memory_wr_out = 1'b0;
    done_out           = 1'b0;
    error_out          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = HEADER;
      end
      HEADER: begin
        byte_ready_out = 1'b1;
        busy_out       = 1'b1;
        if (header_last) begin
          if (header_value == '0)                                     state_d = DONE;
          else if (count_exceeds_depth(header_value, ADDRESS_WIDTH)) state_d = ERROR;
          else                                                        state_d = DATA;
        end
      end
      DATA: begin
        byte_ready_out = 1'b1;
        busy_out       = 1'b1;
        if (word_complete) state_d = WRITE;
      end
      WRITE: begin
        busy_out           = 1'b1;
        data_memory_wr_out = 1'b1;
        state_d            = last_word ? DONE : DATA;
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = start_ok ? HEADER : IDLE;
      end
      ERROR: begin
        error_out = 1'b1;
        if (start_ok) state_d = HEADER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hdr_idx_q <= '0;
      address_q <= '0;
      words_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        count_q   <= '0;
        hdr_idx_q <= '0;
        address_q <= '0;
        words_q   <= '0;
      end
      if (accept && (state_q == HEADER)) begin
        count_q   <= header_value;
        hdr_idx_q <= (hdr_idx_q == HDR_LAST) ? '0 : hdr_idx_q + 1'b1;
      end
      // A full-depth load wraps the address back to 0; no write follows it.
      if (state_q == WRITE) begin
        address_q <= address_q + 1'b1;
        words_q   <= words_next;
      end
    end
  end

endmodule
